result_collector: RTL and testbench

//   Downstream of the systolic array TOP. Consumes the 4x32-bit bottom-row

---
 rtl/result_collector_if.sv | 28 ++
 rtl/result_collector.sv | 82 ++++++++
 tb/tb_result_collector.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/result_collector_if.sv
// result_collector_if: TOP-side run/capture inputs and result-SRAM write outputs of result_collector.
interface result_collector_if #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ROUNDS = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                               startSys;
  logic                               start_check;
  logic [ADDR_WIDTH-1:0]              BankAddr;
  logic [DATA_WIDTH-1:0]              OpC30;
  logic [DATA_WIDTH-1:0]              OpC31;
  logic [DATA_WIDTH-1:0]              OpC32;
  logic [DATA_WIDTH-1:0]              OpC33;
  logic                               WrEn;
  logic [ADDR_WIDTH-1:0]              WrAddr;
  logic [NUM_ROUNDS*4*DATA_WIDTH-1:0] WrData;
  logic [ADDR_WIDTH:0]                CaseCount;
  logic                               Overlap;
  logic                               Done;
  modport master (
    output startSys, start_check, BankAddr, OpC30, OpC31, OpC32, OpC33,
    input  WrEn, WrAddr, WrData, CaseCount, Overlap, Done
  );
  modport slave (
    input  startSys, start_check, BankAddr, OpC30, OpC31, OpC32, OpC33,
    output WrEn, WrAddr, WrData, CaseCount, Overlap, Done
  );
endinterface

// File: rtl/result_collector.sv
// result_collector: gathers NUM_ROUNDS bottom-row rounds per case into one word and writes it to the result SRAM.
module result_collector #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_ROUNDS = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int LAST_ADDR  = 1023
) (
  input logic               clk,
  input logic               rstnSys,
  result_collector_if.slave bus
);
  localparam int LW = 4 * DATA_WIDTH;
  localparam int CW = $clog2(NUM_ROUNDS);
  localparam logic [ADDR_WIDTH:0] CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
  typedef enum logic {IDLE, CAPTURE} state_t;
  state_t                         state_q;
  logic [CW-1:0]                  cnt_q;
  logic [ADDR_WIDTH-1:0]          addr_q;
  logic [LW*(NUM_ROUNDS-1)-1:0]   buf_q;
  logic                           wr_en_q;
  logic [ADDR_WIDTH-1:0]          wr_addr_q;
  logic [LW*NUM_ROUNDS-1:0]       wr_data_q;
  logic [ADDR_WIDTH:0]            case_cnt_q;
  logic                           overlap_q;
  logic                           done_q;
  logic [LW-1:0]                  round;
  logic                           last;
  assign round = {bus.OpC30, bus.OpC31, bus.OpC32, bus.OpC33};
  assign last  = cnt_q == CW'(NUM_ROUNDS - 1);
  // The final round goes straight into the write word; only earlier rounds are buffered.
  always_ff @(posedge clk or negedge rstnSys) begin
    if (!rstnSys) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      buf_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      case_cnt_q <= '0;
      overlap_q  <= 1'b0;
      done_q     <= 1'b0;
    end else if (!bus.startSys) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wr_en_q    <= 1'b0;
      case_cnt_q <= '0;
      overlap_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (state_q == IDLE) begin
        if (bus.start_check) begin
          addr_q       <= bus.BankAddr;
          buf_q[LW-1:0] <= round;
          cnt_q        <= CW'(1);
          state_q      <= CAPTURE;
        end
      end else begin
        if (bus.start_check) overlap_q <= 1'b1;
        if (!last) begin
          buf_q[cnt_q*LW +: LW] <= round;
          cnt_q                 <= cnt_q + 1'b1;
        end else begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= addr_q;
          wr_data_q <= {round, buf_q};
          cnt_q     <= '0;
          state_q   <= IDLE;
          if (case_cnt_q != CNT_MAX) case_cnt_q <= case_cnt_q + 1'b1;
          if (addr_q == ADDR_WIDTH'(LAST_ADDR)) done_q <= 1'b1;
        end
      end
    end
  end
  assign bus.WrEn      = wr_en_q;
  assign bus.WrAddr    = wr_addr_q;
  assign bus.WrData    = wr_data_q;
  assign bus.CaseCount = case_cnt_q;
  assign bus.Overlap   = overlap_q;
  assign bus.Done      = done_q;
endmodule

// File: tb/tb_result_collector.sv
// tb_result_collector: random-data scoreboard bench for result_collector.
module tb_result_collector;
  logic clk = 1'b0;
  logic rstnSys = 1'b0;
  int tests = 0;
  int fails = 0;
  int n_wr = 0;
  int n_push = 0;
  int exp_count = 0;
  bit exp_done = 1'b0;
  logic [9:0]    exp_addr[$];
  logic [1023:0] exp_data[$];

  result_collector_if ifc ();
  result_collector dut (.clk(clk), .rstnSys(rstnSys), .bus(ifc));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic chk_data(input logic [1023:0] exp);
    tests++;
    if (ifc.WrData !== exp) begin
      fails++;
      for (int i = 0; i < 32; i++)
        if (ifc.WrData[i*32 +: 32] !== exp[i*32 +: 32]) begin
          $display("FAIL wrdata lane %0d: got %h expected %h", i, ifc.WrData[i*32 +: 32], exp[i*32 +: 32]);
          break;
        end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      ifc.start_check = 1'b0;
      ifc.BankAddr = 10'($urandom);
      {ifc.OpC30, ifc.OpC31, ifc.OpC32, ifc.OpC33} = {$urandom, $urandom, $urandom, $urandom};
    end
  endtask

  // mode 0: normal, 1: startSys drop at round cut, 2: async reset after round cut
  task automatic run_case(input logic [9:0] addr, input int ovl_at, input int mode, input int cut, input bit det);
    logic [127:0]  rnd[8];
    logic [1023:0] w;
    for (int r = 0; r < 8; r++) begin
      rnd[r] = det ? {32'(4*r), 32'(4*r+1), 32'(4*r+2), 32'(4*r+3)} : {$urandom, $urandom, $urandom, $urandom};
      w[r*128 +: 128] = rnd[r];
    end
    if (mode == 0) begin
      exp_addr.push_back(addr);
      exp_data.push_back(w);
      n_push++;
    end
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      if (mode == 1 && r == cut) begin
        ifc.startSys = 1'b0;
        ifc.start_check = 1'b0;
        exp_count = 0;
        exp_done = 1'b0;
        return;
      end
      if (mode == 2 && r == cut) begin
        @(posedge clk);
        #2 rstnSys = 1'b0;
        #1;
        chk("arst_wren", ifc.WrEn, 0);
        chk("arst_wraddr", ifc.WrAddr, 0);
        chk("arst_wrdata", |ifc.WrData, 0);
        chk("arst_casecount", ifc.CaseCount, 0);
        chk("arst_overlap", ifc.Overlap, 0);
        chk("arst_done", ifc.Done, 0);
        exp_count = 0;
        exp_done = 1'b0;
        @(negedge clk);
        rstnSys = 1'b1;
        ifc.start_check = 1'b0;
        return;
      end
      ifc.start_check = (r == 0) || (r == ovl_at);
      ifc.BankAddr = (r == 0) ? addr : 10'($urandom);
      {ifc.OpC30, ifc.OpC31, ifc.OpC32, ifc.OpC33} = rnd[r];
    end
  endtask

  initial begin
    logic [9:0]    a;
    logic [1023:0] d;
    forever begin
      @(negedge clk);
      if (rstnSys && ifc.WrEn) begin
        n_wr++;
        if (exp_addr.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got WrEn=1 at addr %0d expected no write", ifc.WrAddr);
        end else begin
          a = exp_addr.pop_front();
          d = exp_data.pop_front();
          exp_count = (exp_count == 1024) ? 1024 : exp_count + 1;
          if (a == 10'd1023) exp_done = 1'b1;
          chk("wraddr", ifc.WrAddr, a);
          chk_data(d);
          chk("casecount", ifc.CaseCount, exp_count);
          chk("done", ifc.Done, exp_done);
        end
      end
    end
  end

  initial begin
    ifc.startSys = 1'b0;
    ifc.start_check = 1'b0;
    ifc.BankAddr = '0;
    {ifc.OpC30, ifc.OpC31, ifc.OpC32, ifc.OpC33} = '0;
    #23;
    chk("rst_wren", ifc.WrEn, 0);
    chk("rst_wraddr", ifc.WrAddr, 0);
    chk("rst_wrdata", |ifc.WrData, 0);
    chk("rst_casecount", ifc.CaseCount, 0);
    chk("rst_overlap", ifc.Overlap, 0);
    chk("rst_done", ifc.Done, 0);
    @(negedge clk);
    rstnSys = 1'b1;
    ifc.startSys = 1'b1;
    idle(2);
    run_case(10'd5, -1, 0, 0, 1'b1);
    idle(1);
    chk("t1_wren", ifc.WrEn, 1);
    chk("t1_wraddr", ifc.WrAddr, 5);
    chk("t1_lsb", ifc.WrData[31:0], 3);
    chk("t1_msb", ifc.WrData[1023:992], 28);
    chk("t1_casecount", ifc.CaseCount, 1);
    idle(1);
    chk("t1_wren_pulse", ifc.WrEn, 0);
    run_case(10'd17, -1, 0, 0, 1'b0);
    idle(9);
    run_case(10'd300, -1, 0, 0, 1'b0);
    run_case(10'd301, -1, 0, 0, 1'b0);
    idle(3);
    chk("t2_overlap", ifc.Overlap, 0);
    chk("t2_casecount", ifc.CaseCount, 4);
    run_case(10'd40, 3, 0, 0, 1'b0);
    idle(3);
    chk("t3_overlap", ifc.Overlap, 1);
    chk("t3_casecount", ifc.CaseCount, 5);
    run_case(10'd50, -1, 1, 4, 1'b0);
    idle(12);
    chk("t4_casecount", ifc.CaseCount, 0);
    chk("t4_overlap", ifc.Overlap, 0);
    chk("t4_wren", ifc.WrEn, 0);
    ifc.startSys = 1'b1;
    idle(1);
    run_case(10'd9, -1, 0, 0, 1'b0);
    idle(1);
    chk("t4_wraddr", ifc.WrAddr, 9);
    idle(2);
    run_case(10'd77, -1, 2, 4, 1'b0);
    idle(12);
    chk("t5_casecount", ifc.CaseCount, 0);
    chk("t5_wren", ifc.WrEn, 0);
    for (int i = 0; i < 1024; i++) begin
      if (i == 1023) chk("t6_done_early", ifc.Done, 0);
      run_case(10'(i), -1, 0, 0, 1'b0);
    end
    idle(3);
    chk("t6_done", ifc.Done, 1);
    chk("t6_casecount", ifc.CaseCount, 1024);
    run_case(10'd3, -1, 0, 0, 1'b0);
    idle(3);
    chk("t6_casecount_sat", ifc.CaseCount, 1024);
    chk("t6_done_hold", ifc.Done, 1);
    for (int i = 0; i < 20 && exp_addr.size() != 0; i++) @(negedge clk);
    chk("drain", exp_addr.size(), 0);
    chk("writes", n_wr, n_push);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
